// File: rtl/fetch_queue.sv
// Instruction fetch queue for the IF stage: issues the PC to a synchronous
// instruction memory, buffers {pc, instr} pairs and hands them to decode.
module fetch_queue #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [ADDR_W-1:0]  i_pc_in,
  output logic [ADDR_W-1:0]  o_next_addr,
  output logic               o_pc_halt,
  output logic               o_imem_en,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_flush_target,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [ADDR_W-1:0]  o_out_pc,
  output logic [INSTR_W-1:0] o_out_instr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_inflight_pc;

  logic [CNT_W:0]     w_occupied;
  logic               w_credit_ok;
  logic               w_req;
  logic               w_enq;
  logic               w_deq;
  logic               w_out_valid;

  // Credit counts only registered state, so decode's ready never reaches pc_halt.
  assign w_occupied  = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_credit_ok = w_occupied < (CNT_W+1)'(DEPTH);
  assign w_req       = w_credit_ok & ~i_flush & ~i_reset;

  assign w_out_valid = ~i_reset & (r_count != '0);
  assign w_enq       = r_inflight & ~i_flush & ~i_reset;
  assign w_deq       = w_out_valid & i_out_ready & ~i_flush;

  assign o_imem_en   = w_req;
  assign o_imem_addr = i_reset ? '0 : i_pc_in;
  assign o_pc_halt   = ~w_req & ~i_flush & ~i_reset;

  always_comb begin
    o_next_addr = i_pc_in + ADDR_W'(2);
    if (i_reset)
      o_next_addr = '0;
    else if (i_flush)
      o_next_addr = i_flush_target;
  end

  assign o_out_valid = w_out_valid;
  assign o_out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign o_out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : '0;

  // Storage contents are don't-care after reset/flush, so no reset here.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
      r_instr_mem[r_wr_ptr] <= i_imem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (w_req)
        r_inflight_pc <= i_pc_in;
      if (w_enq)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
